// File: rtl/ram_dma_ci.sv
// rtl/ram_dma_ci.sv - custom-instruction slave around a 512 x 32 single-clock RAM
module ram_dma_ci #(
    parameter logic [7:0] customId = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic [31:0] result,
    output logic        done
);

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    logic [31:0] mem [0:511];
    logic [31:0] read_data;
    state_t      state;

    logic [8:0]  addr;
    logic        is_ram;
    logic        is_write;
    logic        accept;
    logic        write_en;
    logic        read_launch;
    logic        read_done;
    logic        immediate_done;

    // valueA[31:13] carry no meaning for this block
    logic        unused_bits;
    assign unused_bits = ^valueA[31:13];

    assign addr     = valueA[8:0];
    assign is_ram   = (valueA[12:10] == 3'b000);
    assign is_write = valueA[9];

    // A start only counts when addressed to us and no read is outstanding;
    // starts coinciding with reset are dropped so reset leaves nothing behind.
    assign accept         = start && (ciN == customId) && (state == S_IDLE) && !reset;
    assign write_en       = accept && is_ram && is_write;
    assign read_launch    = accept && is_ram && !is_write;
    assign immediate_done = accept && (!is_ram || is_write);

    // Reset in the completion cycle swallows the pending read's done.
    assign read_done = (state == S_READ) && !reset;

    // Writes and non-RAM opcodes finish in the start cycle; reads finish one later.
    // The two sources cannot overlap since accept requires the idle state.
    assign done   = immediate_done || read_done;
    assign result = read_done ? read_data : 32'h0;

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[addr] <= valueB;
        end
    end

    // Registered read port: data captured at the start edge, presented next cycle
    always_ff @(posedge clock) begin
        if (read_launch) begin
            read_data <= mem[addr];
        end
    end

    // Read-pending tracker; the busy window is exactly the cycle after a read start
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (read_launch) begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma_ci.sv
// tb/tb_ram_dma_ci.sv - scoreboard testbench for ram_dma_ci
module tb_ram_dma_ci;

    localparam logic [7:0] CID = 8'h00;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [31:0] result;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    ram_dma_ci #(.customId(CID)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .ciN    (ciN),
        .valueA (valueA),
        .valueB (valueB),
        .result (result),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every done must match the head of the scoreboard in cycle and data
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_done: expected done in cycle %0d, done never asserted (now %0d)", exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_done: done=1 in cycle %0d, result=%h, none required", cyc, result);
            end else begin
                if (result !== exp_q[0].data) begin
                    errors++;
                    $display("FAIL result: cycle %0d got %h, required %h", cyc, result, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end
        end else begin
            checks++;
            if (done !== 1'b0 || result !== 32'h0) begin
                errors++;
                $display("FAIL idle_gating: cycle %0d done=%b result=%h, required done=0 result=0", cyc, done, result);
            end
        end
    end

    // Issue one op for one cycle; lat<0 means no done is expected
    task automatic op(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b,
                      input int lat, input logic [31:0] exp_data);
        exp_t e;
        @(posedge clock); #1;
        start  = 1'b1;
        ciN    = c;
        valueA = a;
        valueB = b;
        if (lat >= 0) begin
            e.cyc  = cyc + lat;
            e.data = exp_data;
            exp_q.push_back(e);
        end
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic direct_check(input string name);
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL %s: done=%b result=%h, required done=0 result=0", name, done, result);
        end
    endtask

    initial begin
        exp_t e;
        reset  = 1'b1;
        start  = 1'b0;
        ciN    = 8'h00;
        valueA = 32'h0;
        valueB = 32'h0;
        repeat (2) @(posedge clock);
        direct_check("reset_state");
        @(posedge clock); #1;
        reset = 1'b0;

        // 1. write then read
        op(CID, 32'h0000_0205, 32'hDEAD_BEEF, 0, 32'h0);
        op(CID, 32'h0000_0005, 32'h0, 1, 32'hDEAD_BEEF);

        // 2. wrong ciN ignored
        op(CID + 8'd1, 32'h0000_0205, 32'h0000_0001, -1, 32'h0);
        op(CID, 32'h0000_0005, 32'h0, 1, 32'hDEAD_BEEF);

        // 3. non-RAM opcodes: immediate done, result 0, RAM untouched
        op(CID, 32'h0000_0400, 32'h1234_5678, 0, 32'h0);
        op(CID, 32'h0000_0605, 32'h1234_5678, 0, 32'h0);
        op(CID, 32'h0000_1C05, 32'h1234_5678, 0, 32'h0);
        op(CID, 32'h0000_0005, 32'h0, 1, 32'hDEAD_BEEF);

        // 4. address boundaries, high bits ignored
        op(CID, 32'h0000_0200, 32'h1111_1111, 0, 32'h0);
        op(CID, 32'h0000_03FF, 32'h2222_2222, 0, 32'h0);
        op(CID, 32'h0000_0000, 32'h0, 1, 32'h1111_1111);
        op(CID, 32'h0000_01FF, 32'h0, 1, 32'h2222_2222);
        op(CID, 32'hFFFF_E1FF, 32'h0, 1, 32'h2222_2222);

        // read-after-write back to back
        op(CID, 32'h0000_02AB, 32'hCAFE_F00D, 0, 32'h0);
        op(CID, 32'h0000_00AB, 32'h0, 1, 32'hCAFE_F00D);

        // 5. reset during the completion cycle drops the read
        @(posedge clock); #1;
        start  = 1'b1;
        ciN    = CID;
        valueA = 32'h0000_01FF;
        @(posedge clock); #1;
        start = 1'b0;
        reset = 1'b1;
        direct_check("reset_mid_read");
        @(posedge clock); #1;
        reset = 1'b0;
        op(CID, 32'h0000_01FF, 32'h0, 1, 32'h2222_2222);

        // 6. busy: start in N+1 is ignored (its write must not land)
        @(posedge clock); #1;
        start  = 1'b1;
        ciN    = CID;
        valueA = 32'h0000_0000;
        e.cyc  = cyc + 1;
        e.data = 32'h1111_1111;
        exp_q.push_back(e);
        @(posedge clock); #1;
        valueA = 32'h0000_0205;
        valueB = 32'h0000_0055;
        @(posedge clock); #1;
        start = 1'b0;
        op(CID, 32'h0000_0005, 32'h0, 1, 32'hDEAD_BEEF);

        repeat (4) @(posedge clock);
        @(negedge clock); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
